// File: rtl/hex7seg_if.sv
// Write-side handshake bundle for hex7seg_scan: a value producer offers a
// full display word (one nibble per digit) with valid/ready flow control.
interface hex7seg_if #(
  parameter int DIGITS = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*DIGITS-1:0]   wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/hex7seg_scan.sv
// hex7seg_scan: multiplexed hexadecimal seven-segment driver.
// Scans DIGITS digits over a shared gfedcba segment bus, each digit lit for
// DIV clocks. New values land in a shadow buffer and are committed to the
// displayed buffer only at a frame boundary, so a frame never mixes values.
// Optional feature: define HEX7SEG_LZB_EN for leading-zero blanking.
module hex7seg_scan #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  hex7seg_if.slave          wr,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en,
  output logic              frame_done
);

  localparam int PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [PC_W-1:0]     pc_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] active_r;
  logic [4*DIGITS-1:0] shadow_r;
  logic                pending_r;
  logic [6:0]          seg_r;
  logic [DIGITS-1:0]   dig_en_r;
  logic                frame_done_r;

  logic                tick_s;
  logic                boundary_s;
  logic                accept_s;
  logic [3:0]          nibble_s;
  logic [6:0]          seg_next_s;
  logic [DIGITS-1:0]   dig_en_next_s;

  // The shadow buffer is free whenever nothing is waiting to be committed.
  assign wr.wr_ready = ~pending_r;

  // Scan timing and write acceptance strobes.
  always_comb begin
    tick_s     = (pc_r == PC_LAST);
    boundary_s = tick_s && (idx_r == IDX_LAST);
    accept_s   = wr.wr_valid && !pending_r;
  end

  // Prescaler and digit index; idx advances once per DIV clocks and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r  <= '0;
      idx_r <= '0;
    end else if (tick_s) begin
      pc_r <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      pc_r <= pc_r + PC_W'(1);
    end
  end

  // Shadow capture on an accepted write; commit to the displayed buffer at
  // a frame boundary. A write can only be accepted while nothing is pending,
  // so capture and commit never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r  <= '0;
      active_r  <= '0;
      pending_r <= 1'b0;
    end else if (accept_s) begin
      shadow_r  <= wr.wr_data;
      pending_r <= 1'b1;
    end else if (boundary_s && pending_r) begin
      active_r  <= shadow_r;
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign nibble_s      = active_r[{idx_r, 2'b00} +: 4];
  assign dig_en_next_s = DIGITS'(1) << idx_r;

`ifdef HEX7SEG_LZB_EN
  logic [DIGITS-1:0] blank_s;
  logic              lead_s;

  // Blank mask: walking down from the top digit, zeros stay blanked until
  // the first non-zero nibble. Digit 0 is never blanked.
  always_comb begin
    lead_s  = 1'b1;
    blank_s = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (active_r[4*i +: 4] != 4'h0) begin
        lead_s = 1'b0;
      end else begin
        lead_s = lead_s;
      end
      blank_s[i] = lead_s;
    end
  end

  assign seg_next_s = blank_s[idx_r] ? 7'h00 : hex_decode(nibble_s);
`else
  assign seg_next_s = hex_decode(nibble_s);
`endif

  // Output registers: pins change one cycle after idx/active, and the
  // frame pulse marks the cycle after each boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= 7'h00;
      dig_en_r     <= '0;
      frame_done_r <= 1'b0;
    end else begin
      seg_r        <= seg_next_s;
      dig_en_r     <= dig_en_next_s;
      frame_done_r <= boundary_s;
    end
  end

  // Pin polarity is applied after the registers, reset values included.
  assign seg        = (ACTIVE_LOW != 0) ? ~seg_r    : seg_r;
  assign dig_en     = (ACTIVE_LOW != 0) ? ~dig_en_r : dig_en_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hex7seg_scan.sv
// Directed self-checking bench for hex7seg_scan: a 4-digit DIV=3 instance
// for scan/commit/backpressure/reset, a 1-digit DIV=1 instance for the
// decode sweep, and a 2-digit active-low instance for pin polarity.
module tb_hex7seg_scan;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  localparam logic [6:0] DEC_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [15:0] BIT6 = 16'b1110_1111_0111_1100;

  hex7seg_if #(.DIGITS(4)) bus ();
  hex7seg_if #(.DIGITS(1)) sw_bus ();
  hex7seg_if #(.DIGITS(2)) inv_bus ();

  logic [6:0] seg, sw_seg, inv_seg;
  logic [3:0] dig_en;
  logic [0:0] sw_dig_en;
  logic [1:0] inv_dig_en;
  logic       frame_done, sw_frame_done, inv_frame_done;

  hex7seg_scan #(.DIGITS(4), .DIV(3), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr(bus.slave),
    .seg(seg), .dig_en(dig_en), .frame_done(frame_done)
  );

  hex7seg_scan #(.DIGITS(1), .DIV(1), .ACTIVE_LOW(0)) u_sweep (
    .clk(clk), .rst_n(rst_n), .wr(sw_bus.slave),
    .seg(sw_seg), .dig_en(sw_dig_en), .frame_done(sw_frame_done)
  );

  hex7seg_scan #(.DIGITS(2), .DIV(2), .ACTIVE_LOW(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .wr(inv_bus.slave),
    .seg(inv_seg), .dig_en(inv_dig_en), .frame_done(inv_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and land on the sampling (falling) edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected logical segment pattern of digit d for a displayed word.
  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int d);
    logic [3:0] nib;
    logic [6:0] pat;
    logic       lead;
    nib  = val[4*d +: 4];
    pat  = DEC_TBL[nib];
    lead = 1'b1;
`ifdef HEX7SEG_LZB_EN
    for (int i = 3; i >= d; i--) begin
      if (val[4*i +: 4] != 4'h0) lead = 1'b0;
    end
    if (d != 0 && lead) pat = 7'h00;
`endif
    return pat;
  endfunction

  // Step until frame_done is seen, bounded by just over one frame.
  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 14 && !seen; i++) begin
      if (frame_done === 1'b1) seen = 1'b1;
      else step();
    end
    chk("frame_wait", {31'd0, seen}, 32'd1);
  endtask

  // From a frame start, check one full frame of the 4-digit instance.
  task automatic check_frame(input logic [15:0] val);
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 3; k++) begin
        step();
        bus.wr_valid = 1'b0;
        chk("scan_dig_en", {28'd0, dig_en}, 32'd1 << d);
        chk("scan_seg", {25'd0, seg}, {25'd0, exp_seg(val, d)});
        chk("scan_frame_done", {31'd0, frame_done}, {31'd0, (d == 3 && k == 2)});
      end
    end
  endtask

  // Offer a word at a frame start, let it commit, then check its frame.
  task automatic write_and_show(input logic [15:0] val);
    bus.wr_data  = val;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    chk("wr_ready_pending", {31'd0, bus.wr_ready}, 32'd0);
    wait_frame();
    chk("wr_ready_commit", {31'd0, bus.wr_ready}, 32'd1);
    check_frame(val);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.wr_valid = 1'b0;     bus.wr_data = 16'h0000;
    sw_bus.wr_valid = 1'b0;  sw_bus.wr_data = 4'h0;
    inv_bus.wr_valid = 1'b0; inv_bus.wr_data = 8'h00;

    // Reset state
    @(negedge clk);
    chk("rst_seg", {25'd0, seg}, 32'h00);
    chk("rst_dig_en", {28'd0, dig_en}, 32'h0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("rst_inv_seg", {25'd0, inv_seg}, 32'h7F);
    chk("rst_inv_dig_en", {30'd0, inv_dig_en}, 32'h3);
    rst_n = 1'b1;

    // First edge after release
    step();
    chk("first_seg", {25'd0, seg}, 32'h3F);
    chk("first_dig_en", {28'd0, dig_en}, 32'h1);
    chk("first_inv_seg", {25'd0, inv_seg}, 32'h40);
    chk("first_inv_dig_en", {30'd0, inv_dig_en}, 32'h2);
    wait_frame();
    check_frame(16'h0000);

    // Decode sweep on the single-digit, DIV=1 instance
    for (int n = 0; n < 16; n++) begin
      sw_bus.wr_data  = n[3:0];
      sw_bus.wr_valid = 1'b1;
      step();
      sw_bus.wr_valid = 1'b0;
      chk("sweep_ready_low", {31'd0, sw_bus.wr_ready}, 32'd0);
      step();
      chk("sweep_ready_high", {31'd0, sw_bus.wr_ready}, 32'd1);
      step();
      chk("sweep_seg", {25'd0, sw_seg}, {25'd0, DEC_TBL[n]});
      chk("sweep_bit6", {31'd0, sw_seg[6]}, {31'd0, BIT6[n]});
      chk("sweep_dig_en", {31'd0, sw_dig_en}, 32'd1);
      chk("sweep_frame_done", {31'd0, sw_frame_done}, 32'd1);
    end

    // Scan order and frame period
    wait_frame();
    write_and_show(16'h1234);

    // Backpressure: 0x5555 is held while 0xAAAA waits for its boundary
    bus.wr_data  = 16'hAAAA;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_data  = 16'h5555;
    for (int i = 0; i < 14 && frame_done !== 1'b1; i++) begin
      chk("bp_ready_low", {31'd0, bus.wr_ready}, 32'd0);
      step();
    end
    chk("bp_boundary", {31'd0, frame_done}, 32'd1);
    chk("bp_ready_high", {31'd0, bus.wr_ready}, 32'd1);
    check_frame(16'hAAAA);
    chk("bp_second_commit", {31'd0, bus.wr_ready}, 32'd1);
    check_frame(16'h5555);

    // Write on the exact boundary cycle with nothing pending
    for (int i = 0; i < 11; i++) step();
    bus.wr_data  = 16'hC0DE;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    chk("coll_boundary", {31'd0, frame_done}, 32'd1);
    chk("coll_ready_low", {31'd0, bus.wr_ready}, 32'd0);
    check_frame(16'h5555);
    chk("coll_ready_high", {31'd0, bus.wr_ready}, 32'd1);
    check_frame(16'hC0DE);

    // Leading-zero patterns (blanked only when the feature is built in)
    write_and_show(16'h0070);
    write_and_show(16'h0000);

    // Reset mid-frame with a write pending at idx=2
    bus.wr_data  = 16'h9999;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_dig_en_before", {28'd0, dig_en}, 32'h2);
    chk("mid_pending_before", {31'd0, bus.wr_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", {25'd0, seg}, 32'h00);
    chk("mid_rst_dig_en", {28'd0, dig_en}, 32'h0);
    chk("mid_rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    chk("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000);
    check_frame(16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
